// File: rtl/sha256_id_pkg.sv
// Shared types and widths for the SHA-256 ID issue/buffer path.
// An ID entry is the issued ID plus the last-ID marker that travels with it.
package sha256_id_pkg;

   localparam int ID_W     = 6;
   localparam int DIGEST_W = 256;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            last;
   } id_entry_t;

endpackage

// File: rtl/sha256_id_fifo.sv
// In-order FIFO of ID entries with asynchronous reset and a synchronous clear.
// The head entry is presented combinationally so the consumer can capture it on its pop edge.
module sha256_id_fifo
   import sha256_id_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      nrst,
   input  logic      sync_rst,
   input  logic      i_push,
   input  id_entry_t i_data,
   input  logic      i_pop,
   output id_entry_t o_data,
   output logic      o_full,
   output logic      o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   id_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   // Guards keep count in 0..DEPTH even if a caller asserts push/pop out of turn.
   assign w_push  = i_push && !o_full && !sync_rst;
   assign w_pop   = i_pop && !o_empty && !sync_rst;
   assign o_data  = r_mem[r_rd_ptr];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
               r_mem[gi] <= i_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (sync_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sha256_id_buf.sv
// Holds issued IDs until their digests return, then emits {digest, id, last}
// through a single registered output stage. Digests return in issue order.
module sha256_id_buf
   import sha256_id_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int ID_W     = 6,
   parameter int DIGEST_W = 256
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                en,
   input  logic                sync_rst,
   input  logic [ID_W-1:0]     id_in,
   input  logic                id_in_last,
   input  logic                id_in_valid,
   output logic                id_in_ready,
   input  logic [DIGEST_W-1:0] hash_in,
   input  logic                hash_in_valid,
   output logic                hash_in_ready,
   output logic [DIGEST_W-1:0] hash_out,
   output logic [ID_W-1:0]     hash_out_id,
   output logic                hash_out_last,
   output logic                hash_out_valid,
   input  logic                hash_out_ready
);

   id_entry_t           w_wr_entry;
   id_entry_t           w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_out_free;
   logic                w_push;
   logic                w_load;

   logic [DIGEST_W-1:0] r_hash_out;
   logic [ID_W-1:0]     r_hash_out_id;
   logic                r_hash_out_last;
   logic                r_hash_out_valid;

   // The output stage can take a new beat when empty or when it is draining this cycle.
   assign w_out_free    = !r_hash_out_valid || hash_out_ready;
   assign id_in_ready   = en && !w_full;
   assign hash_in_ready = en && !w_empty && w_out_free;
   assign w_push        = id_in_valid && id_in_ready;
   assign w_load        = hash_in_valid && hash_in_ready;

   assign w_wr_entry.id   = id_in;
   assign w_wr_entry.last = id_in_last;

   sha256_id_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .nrst     (nrst),
      .sync_rst (sync_rst),
      .i_push   (w_push),
      .i_data   (w_wr_entry),
      .i_pop    (w_load),
      .o_data   (w_head),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_hash_out       <= '0;
         r_hash_out_id    <= '0;
         r_hash_out_last  <= 1'b0;
         r_hash_out_valid <= 1'b0;
      end else if (sync_rst) begin
         r_hash_out_valid <= 1'b0;
      end else if (w_load) begin
         r_hash_out       <= hash_in;
         r_hash_out_id    <= w_head.id;
         r_hash_out_last  <= w_head.last;
         r_hash_out_valid <= 1'b1;
      end else if (r_hash_out_valid && hash_out_ready) begin
         r_hash_out_valid <= 1'b0;
      end
   end

   assign hash_out       = r_hash_out;
   assign hash_out_id    = r_hash_out_id;
   assign hash_out_last  = r_hash_out_last;
   assign hash_out_valid = r_hash_out_valid;

endmodule

// File: tb/tb_sha256_id_buf.sv
// Bench for sha256_id_buf: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sha256_id_buf;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         nrst;
   logic         en;
   logic         sync_rst;
   logic [5:0]   id_in;
   logic         id_in_last;
   logic         id_in_valid;
   logic         id_in_ready;
   logic [255:0] hash_in;
   logic         hash_in_valid;
   logic         hash_in_ready;
   logic [255:0] hash_out;
   logic [5:0]   hash_out_id;
   logic         hash_out_last;
   logic         hash_out_valid;
   logic         hash_out_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sha256_id_buf #(.DEPTH(DEPTH), .ID_W(6), .DIGEST_W(256)) dut (
      .clk            (clk),
      .nrst           (nrst),
      .en             (en),
      .sync_rst       (sync_rst),
      .id_in          (id_in),
      .id_in_last     (id_in_last),
      .id_in_valid    (id_in_valid),
      .id_in_ready    (id_in_ready),
      .hash_in        (hash_in),
      .hash_in_valid  (hash_in_valid),
      .hash_in_ready  (hash_in_ready),
      .hash_out       (hash_out),
      .hash_out_id    (hash_out_id),
      .hash_out_last  (hash_out_last),
      .hash_out_valid (hash_out_valid),
      .hash_out_ready (hash_out_ready)
   );

   function automatic logic [255:0] dig(input logic [31:0] k);
      return {8{k ^ 32'hA5A5_0000}};
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: stored IDs as a queue, output stage as one slot.
   logic [6:0]   mq[$];
   logic         m_ov;
   logic [255:0] m_dig;
   logic [5:0]   m_id;
   logic         m_last;

   // Transfers actually observed on the output handshake.
   logic [5:0]   lg_id[$];
   logic         lg_last[$];
   logic [255:0] lg_dig[$];

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mq.delete();
         m_ov = 1'b0;
      end else begin
         bit out_fire, hacc, iacc;
         logic [6:0] e;
         if (hash_out_valid && hash_out_ready) begin
            lg_id.push_back(hash_out_id);
            lg_last.push_back(hash_out_last);
            lg_dig.push_back(hash_out);
            $display("OUT id=%0d last=%0b digest=%0h", hash_out_id, hash_out_last, hash_out);
         end
         if (sync_rst) begin
            mq.delete();
            m_ov = 1'b0;
         end else begin
            out_fire = m_ov && hash_out_ready;
            hacc = hash_in_valid && en && (mq.size() > 0) && (!m_ov || hash_out_ready);
            iacc = id_in_valid && en && (mq.size() < DEPTH);
            if (hacc) begin
               e      = mq.pop_front();
               m_ov   = 1'b1;
               m_dig  = hash_in;
               m_id   = e[6:1];
               m_last = e[0];
            end else if (out_fire) begin
               m_ov = 1'b0;
            end
            if (iacc) mq.push_back({id_in, id_in_last});
         end
      end
   end

   always @(posedge clk) begin
      #2;
      chk("id_in_ready", id_in_ready, en && (mq.size() < DEPTH));
      chk("hash_in_ready", hash_in_ready, en && (mq.size() > 0) && (!m_ov || hash_out_ready));
      chk("hash_out_valid", hash_out_valid, m_ov);
      if (m_ov) begin
         chk("hash_out", hash_out, m_dig);
         chk("hash_out_id", hash_out_id, m_id);
         chk("hash_out_last", hash_out_last, m_last);
      end
   end

   // All stimulus tasks start and end at a falling edge.
   task automatic push_id(input logic [5:0] id, input logic last);
      int n = 0;
      bit acc = 0;
      id_in = id; id_in_last = last; id_in_valid = 1'b1;
      while (!acc && n < 50) begin
         #1 acc = id_in_ready;
         @(negedge clk);
         n++;
      end
      id_in_valid = 1'b0;
      chk("push_accepted", acc, 1'b1);
   endtask

   task automatic send_hash(input logic [255:0] d);
      int n = 0;
      bit acc = 0;
      hash_in = d; hash_in_valid = 1'b1;
      while (!acc && n < 50) begin
         #1 acc = hash_in_ready;
         @(negedge clk);
         n++;
      end
      hash_in_valid = 1'b0;
      chk("hash_accepted", acc, 1'b1);
   endtask

   task automatic clear_log();
      lg_id.delete(); lg_last.delete(); lg_dig.delete();
   endtask

   initial begin
      nrst = 1'b0; en = 1'b0; sync_rst = 1'b0;
      id_in = '0; id_in_last = 1'b0; id_in_valid = 1'b0;
      hash_in = '0; hash_in_valid = 1'b0; hash_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", hash_out_valid, 1'b0);
      chk("rst_hash", hash_out, 256'd0);
      chk("rst_id", hash_out_id, 6'd0);
      chk("rst_last", hash_out_last, 1'b0);
      chk("rst_id_ready", id_in_ready, 1'b0);
      chk("rst_hash_ready", hash_in_ready, 1'b0);
      nrst = 1'b1; en = 1'b1; hash_out_ready = 1'b1;
      @(negedge clk);

      // Basic order
      clear_log();
      push_id(6'd0, 1'b0); push_id(6'd1, 1'b0); push_id(6'd2, 1'b1);
      send_hash(dig(10)); send_hash(dig(11)); send_hash(dig(12));
      repeat (2) @(negedge clk);
      chk("basic_n", lg_id.size(), 3);
      if (lg_id.size() == 3) begin
         chk("basic_id0", lg_id[0], 6'd0); chk("basic_last0", lg_last[0], 1'b0); chk("basic_d0", lg_dig[0], dig(10));
         chk("basic_id1", lg_id[1], 6'd1); chk("basic_last1", lg_last[1], 1'b0); chk("basic_d1", lg_dig[1], dig(11));
         chk("basic_id2", lg_id[2], 6'd2); chk("basic_last2", lg_last[2], 1'b1); chk("basic_d2", lg_dig[2], dig(12));
      end

      // Empty guard
      hash_in = dig(20); hash_in_valid = 1'b1;
      repeat (3) begin
         #1 chk("empty_hash_ready", hash_in_ready, 1'b0);
         chk("empty_no_out", hash_out_valid, 1'b0);
         @(negedge clk);
      end
      id_in = 6'd5; id_in_last = 1'b0; id_in_valid = 1'b1;
      #1 chk("empty_push_ready", id_in_ready, 1'b1);
      @(negedge clk);
      id_in_valid = 1'b0;
      #1 chk("empty_then_ready", hash_in_ready, 1'b1);
      @(negedge clk);
      hash_in_valid = 1'b0;
      #1 chk("empty_out_valid", hash_out_valid, 1'b1);
      chk("empty_out_id", hash_out_id, 6'd5);
      chk("empty_out_dig", hash_out, dig(20));
      @(negedge clk);

      // Full and wrap
      clear_log();
      for (int i = 0; i < 4; i++) push_id(6'(i), 1'b0);
      #1 chk("full_id_ready", id_in_ready, 1'b0);
      @(negedge clk);
      for (int i = 4; i < 16; i++) begin
         send_hash(dig(100 + i - 4));
         push_id(6'(i), i == 15);
      end
      for (int i = 0; i < 4; i++) send_hash(dig(200 + i));
      repeat (2) @(negedge clk);
      chk("wrap_n", lg_id.size(), 16);
      if (lg_id.size() == 16)
         for (int i = 0; i < 16; i++) chk("wrap_order", lg_id[i], 6'(i));

      // Backpressure
      clear_log();
      push_id(6'd30, 1'b0); push_id(6'd31, 1'b1);
      hash_out_ready = 1'b0;
      send_hash(dig(40));
      hash_in = dig(41); hash_in_valid = 1'b1;
      repeat (5) begin
         #1 chk("bp_hold_dig", hash_out, dig(40));
         chk("bp_hold_id", hash_out_id, 6'd30);
         chk("bp_hash_ready", hash_in_ready, 1'b0);
         @(negedge clk);
      end
      hash_out_ready = 1'b1;
      #1 chk("bp_release_ready", hash_in_ready, 1'b1);
      @(negedge clk);
      hash_in_valid = 1'b0;
      #1 chk("bp_next_id", hash_out_id, 6'd31);
      chk("bp_next_dig", hash_out, dig(41));
      repeat (2) @(negedge clk);
      chk("bp_n", lg_id.size(), 2);

      // Simultaneous push and pop at count 2
      clear_log();
      push_id(6'd40, 1'b0); push_id(6'd41, 1'b0);
      hash_in = dig(50); hash_in_valid = 1'b1;
      id_in = 6'd42; id_in_last = 1'b1; id_in_valid = 1'b1;
      #1 chk("sim_id_ready", id_in_ready, 1'b1);
      chk("sim_hash_ready", hash_in_ready, 1'b1);
      @(negedge clk);
      hash_in_valid = 1'b0; id_in_valid = 1'b0;
      send_hash(dig(51)); send_hash(dig(52));
      repeat (2) @(negedge clk);
      chk("sim_n", lg_id.size(), 3);
      if (lg_id.size() == 3) begin
         chk("sim_id0", lg_id[0], 6'd40); chk("sim_d0", lg_dig[0], dig(50));
         chk("sim_id1", lg_id[1], 6'd41); chk("sim_d1", lg_dig[1], dig(51));
         chk("sim_id2", lg_id[2], 6'd42); chk("sim_last2", lg_last[2], 1'b1);
      end

      // Enable low holds inputs off
      push_id(6'd7, 1'b0);
      en = 1'b0;
      hash_in = dig(60); hash_in_valid = 1'b1;
      repeat (2) begin
         #1 chk("en0_hash_ready", hash_in_ready, 1'b0);
         chk("en0_id_ready", id_in_ready, 1'b0);
         @(negedge clk);
      end
      en = 1'b1;
      #1 chk("en1_hash_ready", hash_in_ready, 1'b1);
      @(negedge clk);
      hash_in_valid = 1'b0;
      #1 chk("en1_out_id", hash_out_id, 6'd7);
      @(negedge clk);

      // Synchronous clear
      clear_log();
      push_id(6'd1, 1'b0); push_id(6'd2, 1'b0); push_id(6'd3, 1'b0);
      hash_out_ready = 1'b0;
      send_hash(dig(70));
      sync_rst = 1'b1;
      @(negedge clk);
      sync_rst = 1'b0;
      #1 chk("srst_valid", hash_out_valid, 1'b0);
      chk("srst_empty", hash_in_ready, 1'b0);
      chk("srst_id_ready", id_in_ready, 1'b1);
      hash_out_ready = 1'b1;
      @(negedge clk);
      push_id(6'd9, 1'b1);
      send_hash(dig(71));
      repeat (2) @(negedge clk);
      chk("srst_n", lg_id.size(), 1);
      if (lg_id.size() == 1) chk("srst_id9", lg_id[0], 6'd9);

      // Asynchronous reset mid-operation
      clear_log();
      push_id(6'd11, 1'b0); push_id(6'd12, 1'b0);
      hash_out_ready = 1'b0;
      send_hash(dig(80));
      nrst = 1'b0;
      #1 chk("nrst_valid", hash_out_valid, 1'b0);
      chk("nrst_hash", hash_out, 256'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      hash_out_ready = 1'b1;
      push_id(6'd13, 1'b0);
      send_hash(dig(81));
      repeat (2) @(negedge clk);
      chk("nrst_n", lg_id.size(), 1);
      if (lg_id.size() == 1) chk("nrst_id13", lg_id[0], 6'd13);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
